// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: round timer FSM with a 1 ms prescaler, pause, timeout and bonus pulses.
// Optional bonus cooldown is enabled by defining TIMER_BONUS_COOLDOWN_EN.
module game_timer_ctrl #(
  parameter int CLK_FREQ_HZ       = 65_000_000,
  parameter int ARM_CYCLES        = 2,
  parameter int BONUS_COOLDOWN_MS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        round_start,
  input  logic        round_abort,
  input  logic        pause,
  input  logic        bonus_req,
  input  logic        elapsed,
  output logic        module_en,
  output logic        start,
  output logic        bonus,
  output logic        one_ms_tick,
  output logic        time_up,
  output logic [19:0] ms_total,
  output logic [7:0]  bonus_count
);

  localparam int TPM = CLK_FREQ_HZ / 1000;
  localparam int PW  = (TPM > 1) ? $clog2(TPM) : 1;
  localparam int AW  = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TPM - 1);
  localparam logic [AW-1:0] ARM_LAST   = AW'(ARM_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_RUN     = 3'd2,
    S_PAUSE   = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t        state_r;
  logic [PW-1:0] presc_r;
  logic [AW-1:0] arm_cnt_r;
  logic          presc_wrap_s;
  logic          grant_s;

`ifdef TIMER_BONUS_COOLDOWN_EN
  localparam logic [15:0] COOLDOWN_LOAD = 16'(BONUS_COOLDOWN_MS);
  logic [15:0] cooldown_r;
`endif

  function automatic logic [19:0] sat_inc20(input logic [19:0] v);
    if (v == 20'hF_FFFF) begin
      return v;
    end else begin
      return v + 20'd1;
    end
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Prescaler terminal detect and bonus grant qualification.
  always_comb begin
    presc_wrap_s = (presc_r == PRESC_LAST);
    grant_s      = 1'b0;
`ifdef TIMER_BONUS_COOLDOWN_EN
    if (bonus_req && (cooldown_r == 16'd0)) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
`else
    grant_s = bonus_req;
`endif
  end

  // Round FSM with all outputs registered; pulses default low each clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      presc_r     <= '0;
      arm_cnt_r   <= '0;
      module_en   <= 1'b0;
      start       <= 1'b0;
      bonus       <= 1'b0;
      one_ms_tick <= 1'b0;
      time_up     <= 1'b0;
      ms_total    <= 20'd0;
      bonus_count <= 8'd0;
`ifdef TIMER_BONUS_COOLDOWN_EN
      cooldown_r  <= 16'd0;
`endif
    end else begin
      start       <= 1'b0;
      bonus       <= 1'b0;
      one_ms_tick <= 1'b0;
      time_up     <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (round_start) begin
            state_r     <= S_ARM;
            module_en   <= 1'b1;
            arm_cnt_r   <= '0;
            ms_total    <= 20'd0;
            bonus_count <= 8'd0;
`ifdef TIMER_BONUS_COOLDOWN_EN
            cooldown_r  <= 16'd0;
`endif
          end else begin
            module_en <= 1'b0;
          end
        end
        S_ARM: begin
          if (round_abort) begin
            state_r   <= S_IDLE;
            module_en <= 1'b0;
          end else if (arm_cnt_r == ARM_LAST) begin
            state_r <= S_RUN;
            start   <= 1'b1;
            presc_r <= '0;
          end else begin
            arm_cnt_r <= arm_cnt_r + AW'(1);
          end
        end
        S_RUN: begin
          if (round_abort) begin
            state_r   <= S_IDLE;
            module_en <= 1'b0;
          end else if (elapsed) begin
            state_r <= S_TIMEOUT;
            time_up <= 1'b1;
          end else if (pause) begin
            state_r <= S_PAUSE;
          end else begin
            if (presc_wrap_s) begin
              presc_r     <= '0;
              one_ms_tick <= 1'b1;
              ms_total    <= sat_inc20(ms_total);
            end else begin
              presc_r <= presc_r + PW'(1);
            end
            if (grant_s) begin
              bonus       <= 1'b1;
              bonus_count <= sat_inc8(bonus_count);
            end else begin
              bonus <= 1'b0;
            end
`ifdef TIMER_BONUS_COOLDOWN_EN
            // A fresh grant reloads the full cooldown even if a tick lands on the same clock.
            if (grant_s) begin
              cooldown_r <= COOLDOWN_LOAD;
            end else if (presc_wrap_s && (cooldown_r != 16'd0)) begin
              cooldown_r <= cooldown_r - 16'd1;
            end else begin
              cooldown_r <= cooldown_r;
            end
`endif
          end
        end
        S_PAUSE: begin
          if (round_abort) begin
            state_r   <= S_IDLE;
            module_en <= 1'b0;
          end else if (elapsed) begin
            state_r <= S_TIMEOUT;
            time_up <= 1'b1;
          end else if (!pause) begin
            state_r <= S_RUN;
          end else begin
            state_r <= S_PAUSE;
          end
        end
        S_TIMEOUT: begin
          if (round_abort) begin
            state_r   <= S_IDLE;
            module_en <= 1'b0;
          end else begin
            state_r <= S_TIMEOUT;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          module_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/game_timer_ctrl.md
GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 65_000_000, system clock frequency; prescaler terminal count is CLK_FREQ_HZ/1000.
REQ-002 SHALL have parameter ARM_CYCLES, default 2, clocks module_en is held high before the start pulse.
REQ-003 SHALL have parameter BONUS_COOLDOWN_MS, default 500, minimum ms between granted bonus pulses.
REQ-004 Ports, in order:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- round_start  in  1  single-cycle pulse; begin a round.
- round_abort  in  1  single-cycle pulse; end the round or acknowledge timeout.
- pause  in  1  level; freezes time.
- bonus_req  in  1  single-cycle pulse; item collected.
- elapsed  in  1  level from the time-bar display block.
- module_en  out  1  enable to the time-bar display block.
- start  out  1  single-cycle pulse that starts the countdown.
- bonus  out  1  single-cycle pulse that grants a bonus refill.
- one_ms_tick  out  1  single-cycle pulse once per ms of unpaused run time.
- time_up  out  1  single-cycle pulse on timeout.
- ms_total  out  20  ms elapsed in the current round.
- bonus_count  out  8  bonuses granted in the current round.

Function
REQ-005 All outputs SHALL be registered.
REQ-006 The FSM SHALL have states S_IDLE, S_ARM, S_RUN, S_PAUSE and S_TIMEOUT.
REQ-007 S_IDLE: module_en=0; round_start -> S_ARM.
REQ-008 S_ARM: module_en=1 for exactly ARM_CYCLES clocks, then -> S_RUN; start=1 in the first S_RUN cycle only; ms_total and bonus_count SHALL clear on entry.
REQ-009 S_RUN: module_en=1; prescaler counts 0..TPM-1 (TPM=CLK_FREQ_HZ/1000); one_ms_tick=1 in the cycle after the count reaches TPM-1; prescaler SHALL clear on entry from S_ARM.
REQ-010 Each one_ms_tick SHALL increment ms_total, saturating at 2^20-1.
REQ-011 S_RUN with pause=1 -> S_PAUSE; S_PAUSE: prescaler and counters held, no tick, module_en=1; pause=0 -> S_RUN with the prescaler value preserved.
REQ-012 S_RUN with bonus_req=1 and the bonus granted -> bonus=1 for one cycle; bonus_count increments, saturating at 255; bonus_req in any other state SHALL be ignored.
REQ-013 S_RUN/S_PAUSE with elapsed=1 -> S_TIMEOUT; time_up=1 for one cycle on entry.
REQ-014 S_TIMEOUT: module_en=1, no ticks, counters frozen; round_abort -> S_IDLE; round_start ignored.
REQ-015 round_abort in S_ARM/S_RUN/S_PAUSE -> S_IDLE; no start, bonus or time_up pulse is generated.
REQ-016 Priority within one cycle SHALL be round_abort > elapsed > pause > bonus_req; a bonus_req that loses SHALL be dropped, not queued.
REQ-017 After any return to S_IDLE, module_en SHALL stay 0 for at least one clock before S_ARM can be entered.
REQ-018 round_start outside S_IDLE SHALL be ignored.

Reset
REQ-019 rst SHALL force state S_IDLE, clear the prescaler and cooldown counters, and drive all outputs 0 (ms_total=0, bonus_count=0).
REQ-020 rst asserted mid-round SHALL take effect at the next clock edge, with no pulse emitted in that cycle.

Configuration
REQ-021 With macro TIMER_BONUS_COOLDOWN_EN defined: a 16-bit cooldown counter loads BONUS_COOLDOWN_MS on each granted bonus and decrements on each one_ms_tick; bonus_req is granted only when the counter is 0; the counter clears on S_ARM entry.
REQ-022 Without TIMER_BONUS_COOLDOWN_EN: no cooldown logic; every bonus_req in S_RUN that wins priority is granted.

Verification (CLK_FREQ_HZ=10_000, TPM=10, ARM_CYCLES=2, BONUS_COOLDOWN_MS=3)
REQ-023 rst released, round_start at cycle 5 -> module_en=1 at cycles 6-7, start=1 at cycle 8, first one_ms_tick 10 cycles into S_RUN, ms_total=1.
REQ-024 25 ticks in S_RUN, then pause for 37 cycles -> no tick while paused, ms_total stays 25; after pause release the next tick follows the preserved prescaler phase.
REQ-025 Macro defined: bonus_req at ms 4, 5 and 8 -> bonus pulses at ms 4 and 8 only, bonus_count=2; macro undefined: 3 pulses, bonus_count=3.
REQ-026 elapsed and bonus_req in the same cycle -> time_up=1, bonus=0, state S_TIMEOUT; round_start there is ignored; round_abort -> module_en=0 next cycle.
REQ-027 round_abort together with elapsed in S_RUN -> S_IDLE, time_up=0; rst mid-S_PAUSE -> all outputs 0 next cycle.
